// File: rtl/sensor_drain_sched.sv
// sensor_drain_sched
//   Runs one sensor acquisition. The sequence is: clear the sctrl buffer, enable
//   capture until sctrl reports full, then drain cnt words into data memory
//   starting at base. The module keeps a wrap-around sum of every word written
//   and raises a sticky done interrupt when the drain completes normally.
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   cfg_start/stop          start pulse, abort level
//   cfg_base/count          destination base word address, word count (0 or >DEPTH = DEPTH)
//   sctrl_full/out          sctrl status and read data (data valid 1 cycle after address)
//   sctrl_en/clear/addr     sctrl capture enable, buffer clear, read address
//   dm_req/addr/wdata/ack   data-memory write handshake
//   irq_clr                 clears done_irq
//   busy, done_irq, sum     status, sticky completion irq, running sum of written words
module sensor_drain_sched #(
  parameter int ADDRWIDTH = 6,
  parameter int DATAWIDTH = 32,
  parameter int DM_AW     = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESET,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic [DM_AW-1:0]     cfg_base,
  input  logic [ADDRWIDTH:0]   cfg_count,
  input  logic                 sctrl_full,
  input  logic [DATAWIDTH-1:0] sctrl_out,
  output logic                 sctrl_en,
  output logic                 sctrl_clear,
  output logic [ADDRWIDTH-1:0] sctrl_addr,
  output logic                 dm_req,
  output logic [DM_AW-1:0]     dm_addr,
  output logic [DATAWIDTH-1:0] dm_wdata,
  input  logic                 dm_ack,
  input  logic                 irq_clr,
  output logic                 busy,
  output logic                 done_irq,
  output logic [DATAWIDTH-1:0] sum
);

  localparam int CW = ADDRWIDTH + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDRWIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_CAPTURE, S_READ, S_FETCH, S_WRITE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        idx_q, idx_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DM_AW-1:0]     base_q, base_d;
  logic [DATAWIDTH-1:0] data_q, data_d;
  logic [DATAWIDTH-1:0] sum_q, sum_d;
  logic                 irq_q, irq_d;
  // Remembers an abort seen while a write is still waiting for ack, so a
  // short stop pulse still ends the run once the handshake completes.
  logic                 stop_pend_q, stop_pend_d;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      base_q      <= '0;
      data_q      <= '0;
      sum_q       <= '0;
      irq_q       <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      base_q      <= base_d;
      data_q      <= data_d;
      sum_q       <= sum_d;
      irq_q       <= irq_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    base_d      = base_q;
    data_d      = data_q;
    sum_d       = sum_q;
    stop_pend_d = stop_pend_q;
    irq_d       = irq_q;

    // Clear first so a set from DONE in the same cycle wins.
    if (irq_clr) irq_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stop_pend_d = 1'b0;
        if (cfg_start && !cfg_stop) begin
          state_d = S_CLEAR;
          base_d  = cfg_base;
          cnt_d   = (cfg_count == '0 || cfg_count > DEPTH) ? DEPTH : cfg_count;
        end
      end
      S_CLEAR: begin
        sum_d   = '0;
        idx_d   = '0;
        state_d = cfg_stop ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
        if (cfg_stop)        state_d = S_IDLE;
        else if (sctrl_full) state_d = S_READ;
      end
      S_READ: begin
        state_d = cfg_stop ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        if (cfg_stop) begin
          state_d = S_IDLE;
        end else begin
          data_d  = sctrl_out;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cfg_stop) stop_pend_d = 1'b1;
        if (dm_ack) begin
          sum_d = sum_q + data_q;
          idx_d = idx_q + 1'b1;
          if (cfg_stop || stop_pend_q)        state_d = S_IDLE;
          else if (idx_q == cnt_q - CW'(1))   state_d = S_DONE;
          else                                state_d = S_READ;
        end
      end
      S_DONE: begin
        irq_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state, so they change only on the
  // clock edge (or immediately on reset) and never glitch on inputs.
  always_comb begin
    sctrl_clear = (state_q == S_CLEAR);
    sctrl_en    = (state_q == S_CAPTURE);
    sctrl_addr  = (state_q == S_READ || state_q == S_FETCH) ? idx_q[ADDRWIDTH-1:0] : '0;
    dm_req      = (state_q == S_WRITE);
    dm_addr     = (state_q == S_WRITE) ? (base_q + DM_AW'(idx_q)) : '0;
    dm_wdata    = (state_q == S_WRITE) ? data_q : '0;
    busy        = (state_q != S_IDLE);
    done_irq    = irq_q;
    sum         = sum_q;
  end

endmodule

// File: tb/tb_sensor_drain_sched.sv
module tb_sensor_drain_sched;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        cfg_start = 1'b0, cfg_stop = 1'b0, irq_clr = 1'b0;
  logic [15:0] cfg_base = '0;
  logic [6:0]  cfg_count = '0;
  logic        sctrl_full = 1'b0;
  logic [31:0] sctrl_out = '0;
  logic        dm_ack = 1'b0;
  logic        sctrl_en, sctrl_clear, dm_req, busy, done_irq;
  logic [5:0]  sctrl_addr;
  logic [15:0] dm_addr;
  logic [31:0] dm_wdata, sum;

  sensor_drain_sched dut (
    .HCLK(HCLK), .HRESET(HRESET), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
    .cfg_base(cfg_base), .cfg_count(cfg_count), .sctrl_full(sctrl_full),
    .sctrl_out(sctrl_out), .sctrl_en(sctrl_en), .sctrl_clear(sctrl_clear),
    .sctrl_addr(sctrl_addr), .dm_req(dm_req), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ack(dm_ack), .irq_clr(irq_clr), .busy(busy),
    .done_irq(done_irq), .sum(sum)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Sensor model: buffer contents, full after full_delay enabled cycles.
  logic [31:0] mem [64];
  int full_delay = 5;
  int en_cnt = 0;
  // Memory model: ack after ack_delay waiting cycles, logs every transfer.
  int ack_delay = 0;
  int wait_cnt = 0;
  logic [15:0] wa[$];
  logic [31:0] wd[$];
  int stab_viol = 0;
  logic        pend = 1'b0;
  logic [15:0] pend_a;
  logic [31:0] pend_d;

  always @(negedge HCLK) begin
    if (HRESET) begin
      en_cnt = 0; sctrl_full = 1'b0; sctrl_out = '0;
      dm_ack = 1'b0; wait_cnt = 0; pend = 1'b0;
    end else begin
      if (sctrl_clear) en_cnt = 0;
      else if (sctrl_en) en_cnt = en_cnt + 1;
      sctrl_full = (en_cnt >= full_delay);
      sctrl_out  = mem[sctrl_addr];
      if (dm_req) begin
        if (pend && (dm_addr !== pend_a || dm_wdata !== pend_d)) stab_viol++;
        if (wait_cnt >= ack_delay) begin
          dm_ack = 1'b1; wait_cnt = 0; pend = 1'b0;
          wa.push_back(dm_addr); wd.push_back(dm_wdata);
        end else begin
          dm_ack = 1'b0; wait_cnt++; pend = 1'b1;
          pend_a = dm_addr; pend_d = dm_wdata;
        end
      end else begin
        dm_ack = 1'b0; wait_cnt = 0; pend = 1'b0;
      end
    end
  end

  task automatic start(input logic [15:0] base, input logic [6:0] cnt);
    wa.delete(); wd.delete(); stab_viol = 0;
    @(negedge HCLK);
    cfg_base = base; cfg_count = cnt; cfg_start = 1'b1;
    @(negedge HCLK);
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) @(negedge HCLK);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 500 && !dm_req; i++) @(negedge HCLK);
    check({tag, "_req_seen"}, {31'd0, dm_req}, 32'd1);
  endtask

  task automatic run(input logic [15:0] base, input logic [6:0] cnt, input int fd, input int ad, input string tag);
    full_delay = fd; ack_delay = ad;
    start(base, cnt);
    wait_idle(tag);
  endtask

  task automatic clear_irq();
    @(negedge HCLK); irq_clr = 1'b1;
    @(negedge HCLK); irq_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hA0 + i;
    repeat (3) @(negedge HCLK);
    // Reset state
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_irq", {31'd0, done_irq}, 0);
    check("rst_sum", sum, 0);
    check("rst_outs", {sctrl_en, sctrl_clear, dm_req, 26'd0, sctrl_addr == 6'd0 ? 1'b0 : 1'b1, dm_addr != 0, dm_wdata != 0}, 0);
    HRESET = 1'b0;

    // T1: basic drain
    run(16'h0100, 7'd4, 5, 0, "t1");
    check("t1_nwr", wa.size(), 4);
    check("t1_a0", wa[0], 32'h100);
    check("t1_d0", wd[0], 32'hA0);
    check("t1_a3", wa[3], 32'h103);
    check("t1_d3", wd[3], 32'hA3);
    check("t1_sum", sum, 32'h286);
    check("t1_irq", {31'd0, done_irq}, 1);
    clear_irq();
    check("irq_clr", {31'd0, done_irq}, 0);

    // T2: count 0 and count>DEPTH give 64 words; address wrap
    run(16'h2000, 7'd0, 5, 0, "t2a");
    check("t2a_nwr", wa.size(), 64);
    check("t2a_last", wa[63], 32'h203F);
    check("t2a_sum", sum, 32'h2FE0);
    run(16'h2000, 7'd100, 0, 0, "t2b");
    check("t2b_nwr", wa.size(), 64);
    run(16'hFFFE, 7'd4, 5, 0, "t2c");
    check("t2c_a0", wa[0], 32'hFFFE);
    check("t2c_a1", wa[1], 32'hFFFF);
    check("t2c_a2", wa[2], 32'h0000);
    check("t2c_a3", wa[3], 32'h0001);

    // T3: slow ack
    run(16'h0040, 7'd3, 5, 3, "t3");
    check("t3_nwr", wa.size(), 3);
    check("t3_stable", stab_viol, 0);
    check("t3_d2", wd[2], 32'hA2);
    check("t3_sum", sum, 32'h1E3);

    // T4a: abort during capture
    clear_irq();
    full_delay = 20; ack_delay = 0;
    start(16'h0200, 7'd4);
    for (int i = 0; i < 50 && !sctrl_en; i++) @(negedge HCLK);
    check("t4a_en_seen", {31'd0, sctrl_en}, 1);
    repeat (2) @(negedge HCLK);
    cfg_stop = 1'b1;
    @(negedge HCLK);
    cfg_stop = 1'b0;
    check("t4a_en_low", {31'd0, sctrl_en}, 0);
    check("t4a_busy", {31'd0, busy}, 0);
    repeat (3) @(negedge HCLK);
    check("t4a_nwr", wa.size(), 0);
    check("t4a_irq", {31'd0, done_irq}, 0);
    check("t4a_sum", sum, 0);

    // T4b: abort during write, ack at +2
    full_delay = 5; ack_delay = 2;
    start(16'h0300, 7'd4);
    wait_req("t4b");
    cfg_stop = 1'b1;
    wait_idle("t4b");
    cfg_stop = 1'b0;
    check("t4b_nwr", wa.size(), 1);
    check("t4b_a0", wa[0], 32'h300);
    check("t4b_d0", wd[0], 32'hA0);
    check("t4b_sum", sum, 32'hA0);
    check("t4b_irq", {31'd0, done_irq}, 0);

    // start and stop together in IDLE
    @(negedge HCLK); cfg_start = 1'b1; cfg_stop = 1'b1;
    @(negedge HCLK); cfg_start = 1'b0; cfg_stop = 1'b0;
    check("startstop_busy", {31'd0, busy}, 0);

    // T5: sum overflow, irq_clr held through DONE
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'hFFFF_FFFF;
    irq_clr = 1'b1;
    run(16'h0400, 7'd2, 5, 0, "t5");
    irq_clr = 1'b0;
    check("t5_sum", sum, 32'hFFFF_FFFE);
    check("t5_irq_set_wins", {31'd0, done_irq}, 1);
    mem[0] = 32'hA0; mem[1] = 32'hA1;

    // T6: async reset mid-write
    full_delay = 5; ack_delay = 0;
    start(16'h0500, 7'd8);
    for (int i = 0; i < 200 && wa.size() < 2; i++) @(negedge HCLK);
    ack_delay = 10;
    wait_req("t6");
    #2 HRESET = 1'b1;
    #1;
    check("t6_req", {31'd0, dm_req}, 0);
    check("t6_busy", {31'd0, busy}, 0);
    check("t6_addr", dm_addr, 0);
    check("t6_wdata", dm_wdata, 0);
    check("t6_sum", sum, 0);
    check("t6_irq", {31'd0, done_irq}, 0);
    @(negedge HCLK); @(negedge HCLK);
    HRESET = 1'b0;
    run(16'h0600, 7'd2, 5, 0, "t6r");
    check("t6r_nwr", wa.size(), 2);
    check("t6r_a1", wa[1], 32'h601);
    check("t6r_sum", sum, 32'h141);
    check("t6r_irq", {31'd0, done_irq}, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
